// File: rtl/tweet_store_pkg.sv
// rtl/tweet_store_pkg.sv - shared state types and bit-timing helper for the tweet store
package tweet_store_pkg;

  // Store/playback controller states
  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    P_FETCH,
    P_SEND
  } state_e;

  // UART frame receiver states
  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_e;

  // Timer value at which the start bit is re-checked (middle of the start bit)
  function automatic int unsigned half_bit(input int unsigned clks_per_bit);
    return clks_per_bit / 2 - 1;
  endfunction

endpackage

// File: rtl/tweet_rx.sv
// rtl/tweet_rx.sv - serial-line synchroniser and UART frame receiver
module tweet_rx
  import tweet_store_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 active_i,
  input  logic                 serial_i,
  output logic                 serial_sync_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 frm_err_o
);

  localparam int              TW          = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]   HALF_C      = TW'(half_bit(CLKS_PER_BIT));
  localparam logic [TW-1:0]   LAST_C      = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]   ONE_C       = TW'(1);
  localparam logic [3:0]      BITS_LAST_C = 4'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 line;
  rx_state_e            rx_state_q, rx_state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  assign line          = sync_q[1];
  assign serial_sync_o = line;
  assign rx_data_o     = data_q;
  assign rx_valid_o    = valid_q;
  assign frm_err_o     = ferr_q;

  // Two-flop synchroniser; the line idles high so reset loads ones
  always_ff @(posedge clk_i) begin
    if (reset_i) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], serial_i};
  end

  // Frame state, bit timer, shift register and result pulses
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_state_q <= R_IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  // Next-state: find the start edge, confirm it mid-bit, then sample every bit time
  always_comb begin
    rx_state_d = rx_state_q;
    timer_d    = timer_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        timer_d = '0;
        if (active_i && !line) rx_state_d = R_START;
      end
      R_START: begin
        if (timer_q == HALF_C) begin
          timer_d    = '0;
          bit_cnt_d  = '0;
          rx_state_d = line ? R_IDLE : R_DATA;
        end else begin
          timer_d = timer_q + ONE_C;
        end
      end
      R_DATA: begin
        if (timer_q == LAST_C) begin
          timer_d   = '0;
          data_d    = {line, data_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == BITS_LAST_C) rx_state_d = R_STOP;
        end else begin
          timer_d = timer_q + ONE_C;
        end
      end
      R_STOP: begin
        if (timer_q == LAST_C) begin
          timer_d    = '0;
          rx_state_d = R_IDLE;
          if (line) valid_d = 1'b1;
          else      ferr_d  = 1'b1;
        end else begin
          timer_d = timer_q + ONE_C;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
    // While the store is being erased the receiver is parked and drops any frame in flight
    if (!enable_i) begin
      rx_state_d = R_IDLE;
      timer_d    = '0;
    end
  end

endmodule

// File: rtl/tweet_store.sv
// rtl/tweet_store.sv - backspace-aware serial character store with handshake playback; TWEET_STORE_ECHO_EN enables serial echo
module tweet_store
  import tweet_store_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int DEPTH        = 160,
  parameter int ADDR_W       = 8,
  parameter int BS_CODE      = 8
) (
  input  logic                 sysclk_i,
  input  logic                 reset_i,
  input  logic                 active_i,
  input  logic                 serial_in_i,
  input  logic                 play_i,
  input  logic                 clr_i,
  output logic [DATA_BITS-1:0] tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic [ADDR_W-1:0]    count_o,
  output logic                 full_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 ovf_o,
  output logic                 frm_err_o,
  output logic                 rx_drop_o,
  output logic                 serial_echo_o
);

  // Count carries one extra bit so that DEPTH == 2**ADDR_W is still representable
  localparam int                   CW      = ADDR_W + 1;
  localparam int                   MW      = $clog2(DEPTH);
  localparam logic [CW-1:0]        DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]        LAST_C  = CW'(DEPTH - 1);
  localparam logic [CW-1:0]        ONE_C   = CW'(1);
  localparam logic [DATA_BITS-1:0] BS_C    = DATA_BITS'(BS_CODE);

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        clr_addr_q, clr_addr_d;
  logic                 empty_done_q, empty_done_d;
  logic [DATA_BITS-1:0] rd_data_q;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic                 mem_we;
  logic [MW-1:0]        mem_waddr;
  logic [DATA_BITS-1:0] mem_wdata;

  logic                 rx_sync;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_frm_err;
  logic                 rx_drop;
  logic                 ovf;
  logic                 last_hs;

  tweet_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS)
  ) u_rx (
    .clk_i         (sysclk_i),
    .reset_i       (reset_i),
    .enable_i      (state_q != CLEAR),
    .active_i      (active_i),
    .serial_i      (serial_in_i),
    .serial_sync_o (rx_sync),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .frm_err_o     (rx_frm_err)
  );

  assign last_hs    = (state_q == P_SEND) && tx_ready_i && ((rd_ptr_q + ONE_C) == count_q);
  assign tx_valid_o = (state_q == P_SEND);
  assign tx_data_o  = rd_data_q;
  assign count_o    = count_q[ADDR_W-1:0];
  assign full_o     = (count_q == DEPTH_C);
  assign busy_o     = (state_q != IDLE);
  assign done_o     = empty_done_q | last_hs;
  assign ovf_o      = ovf;
  assign rx_drop_o  = rx_drop;
  assign frm_err_o  = rx_frm_err;

`ifdef TWEET_STORE_ECHO_EN
  assign serial_echo_o = (state_q == IDLE && !full_o) ? rx_sync : 1'b1;
`else
  logic unused_sync;
  assign unused_sync   = rx_sync;
  assign serial_echo_o = 1'b1;
`endif

  // Character array: zero-fill while clearing, append while idle
  always_ff @(posedge sysclk_i) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Controller registers and the synchronous read port feeding tx_data
  always_ff @(posedge sysclk_i) begin
    if (reset_i) begin
      state_q      <= CLEAR;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      clr_addr_q   <= '0;
      empty_done_q <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      clr_addr_q   <= clr_addr_d;
      empty_done_q <= empty_done_d;
      if (state_q == P_FETCH) rd_data_q <= mem[rd_ptr_q[MW-1:0]];
    end
  end

  // Next-state: apply the received byte first, then let an idle command see the updated count
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    clr_addr_d   = clr_addr_q;
    empty_done_d = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = count_q[MW-1:0];
    mem_wdata    = rx_data;
    rx_drop      = 1'b0;
    ovf          = 1'b0;

    if (rx_valid) begin
      if (state_q != IDLE) begin
        rx_drop = 1'b1;
      end else if (rx_data == BS_C) begin
        if (count_q != '0) count_d = count_q - ONE_C;
      end else if (count_q < DEPTH_C) begin
        mem_we  = 1'b1;
        count_d = count_q + ONE_C;
      end else begin
        ovf = 1'b1;
      end
    end

    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q[MW-1:0];
        mem_wdata = '0;
        count_d   = '0;
        if (clr_addr_q == LAST_C) state_d = IDLE;
        else                      clr_addr_d = clr_addr_q + ONE_C;
      end
      IDLE: begin
        if (active_i && clr_i) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end else if (active_i && play_i) begin
          if (count_d != '0) begin
            state_d  = P_FETCH;
            rd_ptr_d = '0;
          end else begin
            empty_done_d = 1'b1;
          end
        end
      end
      P_FETCH: state_d = P_SEND;
      P_SEND: begin
        if (tx_ready_i) begin
          if (last_hs) begin
            state_d = IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + ONE_C;
            state_d  = P_FETCH;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

endmodule

// File: tb/tb_tweet_store.sv
// tb/tb_tweet_store.sv - randomized self-checking bench for tweet_store against a queue model
module tb_tweet_store;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int DEP = 4;
  localparam int AW  = 8;

  logic          clk = 1'b0;
  logic          reset, active, serial, play, clr, tx_ready;
  logic [DB-1:0] tx_data;
  logic          tx_valid;
  logic [AW-1:0] count;
  logic          full, busy, done, ovf, frm_err, rx_drop, serial_echo;

  tweet_store #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .DEPTH        (DEP),
    .ADDR_W       (AW),
    .BS_CODE      (8)
  ) dut (
    .sysclk_i      (clk),
    .reset_i       (reset),
    .active_i      (active),
    .serial_in_i   (serial),
    .play_i        (play),
    .clr_i         (clr),
    .tx_data_o     (tx_data),
    .tx_valid_o    (tx_valid),
    .tx_ready_i    (tx_ready),
    .count_o       (count),
    .full_o        (full),
    .busy_o        (busy),
    .done_o        (done),
    .ovf_o         (ovf),
    .frm_err_o     (frm_err),
    .rx_drop_o     (rx_drop),
    .serial_echo_o (serial_echo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0, done_hs = 0, ovf_cnt = 0, frm_cnt = 0, drop_cnt = 0, valid_cnt = 0;
  int exp_ovf = 0, exp_frm = 0, exp_drop = 0;
  int hold_err = 0;
  bit hold_pend = 1'b0;
  logic [DB-1:0] held;
  logic [DB-1:0] model[$];
  logic [DB-1:0] tx_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Passive monitor on the falling edge: pulse counters, handshakes, hold stability
  always @(negedge clk) begin
    if (hold_pend && !(tx_valid && tx_data == held)) hold_err++;
    hold_pend = tx_valid && !tx_ready && !reset;
    held      = tx_data;
    if (done) done_cnt++;
    if (done && tx_valid && tx_ready) done_hs++;
    if (ovf) ovf_cnt++;
    if (frm_err) frm_cnt++;
    if (rx_drop) drop_cnt++;
    if (tx_valid) valid_cnt++;
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
  end

  task automatic do_reset();
    int n;
    reset = 1'b1;
    tick(1);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 1);
    tick(1);
    check("rst_tx_data", tx_data, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_pulses", {done, ovf, frm_err, rx_drop}, 0);
    check("rst_echo", serial_echo, 1);
    reset = 1'b0;
    n = 0;
    while (busy && n < 50) begin tick(1); n++; end
    check("rst_clear_cycles", n, DEP);
    check("rst_clear_count", count, 0);
    model.delete();
  endtask

  task automatic do_clr();
    int n;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_busy", busy, 1);
    n = 0;
    while (busy && n < 50) begin tick(1); n++; end
    check("clr_cycles", n, DEP);
    check("clr_count", count, 0);
    model.delete();
  endtask

  // mode 0: store idle, 1: store busy (expect drop), 2: block inactive (frame ignored)
  task automatic send_byte(input logic [DB-1:0] b, input bit stop_ok, input int mode);
    if (mode == 2) active = 1'b0;
    serial = 1'b0;
    tick(CPB);
    for (int i = 0; i < DB; i++) begin
      serial = b[i];
      tick(CPB);
    end
    serial = stop_ok;
    tick(CPB);
    serial = 1'b1;
    tick(20);
    active = 1'b1;
    if (mode == 2) begin
    end else if (!stop_ok) exp_frm++;
    else if (mode == 1) exp_drop++;
    else if (b == 8'h08) begin
      if (model.size() > 0) void'(model.pop_back());
    end else if (model.size() < DEP) model.push_back(b);
    else exp_ovf++;
    check("ovf_cnt", ovf_cnt, exp_ovf);
    check("frm_cnt", frm_cnt, exp_frm);
    check("drop_cnt", drop_cnt, exp_drop);
    check("count", count, model.size());
    check("full", full, model.size() == DEP);
  endtask

  task automatic do_play(input bit rnd_ready);
    int n, d0, h0;
    d0 = done_cnt;
    h0 = done_hs;
    tx_q.delete();
    play = 1'b1;
    tick(1);
    play = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
      tick(1);
      n++;
    end
    tx_ready = 1'b1;
    tick(2);
    check("play_timeout", n < 400, 1);
    check("play_done_cnt", done_cnt - d0, 1);
    check("play_done_on_hs", done_hs - h0, model.size() > 0);
    check("play_len", tx_q.size(), model.size());
    for (int i = 0; i < tx_q.size() && i < model.size(); i++)
      check($sformatf("play_byte%0d", i), tx_q[i], model[i]);
    check("play_count_kept", count, model.size());
  endtask

  initial begin
    int v0, d0, n, nb;
    logic [DB-1:0] b;
    reset = 1'b1; active = 1'b1; serial = 1'b1; play = 1'b0; clr = 1'b0; tx_ready = 1'b1;
    do_reset();

    // play on an empty store
    v0 = valid_cnt;
    d0 = done_cnt;
    play = 1'b1;
    tick(1);
    play = 1'b0;
    check("empty_done_next", done, 1);
    tick(3);
    check("empty_done_cnt", done_cnt - d0, 1);
    check("empty_no_valid", valid_cnt - v0, 0);

    send_byte(8'h48, 1'b1, 0);
    send_byte(8'h69, 1'b1, 0);
    do_play(1'b0);

    // inactive: frame and play both ignored
    send_byte(8'h5a, 1'b1, 2);
    d0 = done_cnt;
    active = 1'b0; play = 1'b1;
    tick(1);
    play = 1'b0; active = 1'b1;
    tick(3);
    check("inactive_play_done", done_cnt - d0, 0);
    check("inactive_play_busy", busy, 0);

    do_clr();
    send_byte(8'h41, 1'b1, 0);
    send_byte(8'h42, 1'b1, 0);
    send_byte(8'h08, 1'b1, 0);
    send_byte(8'h43, 1'b1, 0);
    do_play(1'b1);

    do_clr();
    send_byte(8'h08, 1'b1, 0);
    for (int i = 0; i < DEP + 1; i++) send_byte(8'h30 + 8'(i), 1'b1, 0);
    check("full_echo", serial_echo, 1);
    do_play(1'b1);

    do_clr();
    send_byte(8'h55, 1'b1, 0);
    send_byte(8'h33, 1'b0, 0);

    // short low glitch on the line
    n = frm_cnt;
    serial = 1'b0;
    tick(3);
`ifdef TWEET_STORE_ECHO_EN
    check("glitch_echo", serial_echo, 0);
`else
    check("glitch_echo", serial_echo, 1);
`endif
    tick(3);
    serial = 1'b1;
    tick(30);
    check("glitch_no_frm", frm_cnt - n, 0);
    check("glitch_count", count, model.size());
    send_byte(8'h21, 1'b1, 0);
    do_play(1'b1);

    // stall the transmitter, then hit it with a frame and a reset
    tx_ready = 1'b0;
    play = 1'b1;
    tick(1);
    play = 1'b0;
    n = 0;
    while (!tx_valid && n < 10) begin tick(1); n++; end
    check("stall_valid_wait", n < 10, 1);
    tick(20);
    check("stall_valid", tx_valid, 1);
    check("stall_data", tx_data, model[0]);
    send_byte(8'h77, 1'b1, 1);
    check("stall_still_valid", tx_valid, 1);
    do_reset();
    tx_ready = 1'b1;

    for (int r = 0; r < 6; r++) begin
      do_clr();
      nb = $urandom_range(0, 6);
      for (int i = 0; i < nb; i++) begin
        b = ($urandom_range(0, 3) == 0) ? 8'h08 : 8'($urandom_range(0, 255));
        send_byte(b, $urandom_range(0, 7) != 0, 0);
      end
      do_play(1'b1);
    end

    check("tx_hold_stable", hold_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tweet_store.md
Name: tweet_store

Overview:
- Parametrised serial message buffer: a UART receiver feeds a backspace-aware character store.
- On command, the store is played back byte-by-byte through a valid/ready handshake to the serial transmitter.
- Generalises the fixed 160-character, 8-bit, 9600-baud tweet board with:
  - configurable bit time, data width and depth;
  - framing-error detection;
  - overflow, drop and done status;
  - an explicit clear command.

Parameters:
- CLKS_PER_BIT, 5208, sysclk cycles per serial bit (minimum 4).
- DATA_BITS, 8, data bits per frame (5..9), LSB first.
- DEPTH, 160, maximum stored characters (2..2**ADDR_W).
- ADDR_W, 8, pointer/count width.
- BS_CODE, 8, character value treated as backspace (compared over DATA_BITS).

Ports:
- sysclk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- active  in  1  block enable; when low, new frames and new commands are ignored.
- serial_in  in  1  async serial line, idle high; double-flopped internally.
- play  in  1  one-cycle pulse (debounced upstream); start playback.
- clr  in  1  one-cycle pulse; erase the store.
- tx_data  out  DATA_BITS  character to transmit.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts tx_data this cycle.
- count  out  ADDR_W  number of characters stored.
- full  out  1  count == DEPTH.
- busy  out  1  high in CLEAR or PLAY state.
- done  out  1  one-cycle pulse at the end of playback.
- ovf  out  1  one-cycle pulse; character discarded because the store is full.
- frm_err  out  1  one-cycle pulse; stop bit sampled low.
- rx_drop  out  1  one-cycle pulse; character received while busy, discarded.
- serial_echo  out  1  see Optional Feature.

Behaviour:
- Reset values:
  - tx_valid=0, tx_data=0, count=0, full=0, busy=1, all pulses 0, serial_echo=1.
  - State goes to CLEAR and the receiver goes to R_IDLE.
  - Reset mid-frame or mid-playback aborts immediately; a partial frame is lost.
- CLEAR:
  - Writes 0 to mem[0..DEPTH-1], one address per cycle (DEPTH cycles), then enters IDLE.
  - count is held at 0 throughout.
  - clr issued in IDLE enters CLEAR; clr in PLAY or CLEAR is ignored.
- Receiver, states R_IDLE / R_START / R_DATA / R_STOP, with bit timer 0..CLKS_PER_BIT-1:
  - R_IDLE→R_START when synchronised serial_in is 0 and active is 1.
  - R_START: at timer == CLKS_PER_BIT/2 - 1, line still 0 → R_DATA with timer restarted; line 1 → glitch, back to R_IDLE with no pulse.
  - R_DATA: samples one bit every CLKS_PER_BIT cycles (mid-bit), DATA_BITS times.
  - R_STOP: samples once. A 1 produces a one-cycle rx_valid to the store logic; a 0 pulses frm_err and the byte is discarded. Either way → R_IDLE.
  - The receiver runs in every state except CLEAR; a start bit during CLEAR is ignored.
- Store, on rx_valid:
  - busy=1: pulse rx_drop; no change.
  - byte == BS_CODE, count>0: count decrements; the entry is left in place (overwritten later).
  - byte == BS_CODE, count==0: ignored, no pulse.
  - otherwise, count<DEPTH: mem[count] is written and count increments in the same cycle.
  - otherwise, count==DEPTH: pulse ovf; no change.
  - Backspace is never stored.
- Playback, states IDLE / P_FETCH / P_SEND:
  - play and active in IDLE with count>0 → P_FETCH with rd_ptr=0.
  - play with count==0 → done pulses next cycle; stays IDLE.
  - Memory read is synchronous, 1 cycle: P_FETCH drives the address, P_SEND asserts tx_valid with tx_data=mem[rd_ptr].
  - tx_valid and tx_data are held stable until tx_ready.
  - On the handshake, tx_valid drops for the fetch cycle and rd_ptr increments. If rd_ptr+1 == count, go to IDLE and pulse done in the handshake cycle.
  - Maximum throughput is one character per 2 cycles.
  - count is frozen during PLAY; play re-asserted during PLAY is ignored.
  - active going low during PLAY does not abort playback.
- Simultaneous events:
  - play and clr in the same IDLE cycle: clr wins.
  - rx_valid in the same cycle as a command accepted from IDLE: the byte is stored first; the command uses the updated count.

Optional Feature:
- TWEET_STORE_ECHO_EN defined: serial_echo = synchronised serial_in when state is IDLE and full==0; otherwise 1.
  - This gives a live echo that goes silent once the store is full.
- Not defined: serial_echo is tied to 1 and no echo logic is built.

Decomposition:
- Package tweet_store_pkg holds:
  - the state enum (CLEAR, IDLE, P_FETCH, P_SEND);
  - the receiver state enum;
  - a function computing the half-bit constant.
- One sub-module, tweet_rx: synchroniser plus UART frame receiver.
  - Parameters: CLKS_PER_BIT, DATA_BITS.
  - Outputs: rx_data, rx_valid, frm_err.
- Storage is an inferred synchronous-read array inside tweet_store.

Test Plan:
- All scenarios use CLKS_PER_BIT=16, DEPTH=4, DATA_BITS=8.
- Reset, then wait 4 cycles → busy falls, count=0; play → done one cycle later, tx_valid never high.
- Send 'H','i' then play with tx_ready held at 1 → tx_data 0x48 then 0x69, done pulses on the second handshake, count stays 2.
- Send 'A','B',0x08,'C' then play → playback is 0x41, 0x43; also send 0x08 with count=0 → count stays 0, no pulses.
- Send 5 characters into DEPTH=4 → ovf pulses once on the 5th; count=4, full=1; echo (macro on) is 1 after the 4th.
- Stop bit driven 0 → frm_err pulses, count unchanged. A 6-cycle low glitch → no pulse, receiver returns to idle.
- Hold tx_ready=0 for 20 cycles during playback → tx_data stable. A frame arriving meanwhile → rx_drop pulses. Reset mid-playback → tx_valid=0 next cycle, CLEAR runs.
